// File: rtl/delay_line_arb.sv
// ----------------------------------------------------------------------------
// delay_line_arb
//   Round-robin arbiter feeding a shared, programmable-depth delay pipeline.
//   One requester is granted per cycle; its data word and index enter stage 1
//   and appear on dout exactly cur_dly cycles after the grant edge.
//   Writing a new delay drains the pipeline before the new value is applied,
//   so no in-flight word is dropped or duplicated.
//
//   Optional feature macro: GRANT_CNT_EN (adds per-requester 16-bit
//   saturating grant counters on port gnt_cnt).
//
// Ports:
//   clk       in   clock, all state changes on posedge
//   rst       in   asynchronous active-high reset
//   req       in   [NREQ]      level requests, held until granted
//   din       in   [NREQ*DW]   requester i data at [i*DW +: DW]
//   gnt       out  [NREQ]      one-hot grant (combinational), zero in DRAIN
//   cfg_wr    in   1           single-cycle strobe to load cfg_dly
//   cfg_dly   in   [DLW]       requested delay (clamped to 1..MAX_DLY)
//   cfg_busy  out  1           reconfiguration in progress (draining)
//   cur_dly   out  [DLW]       delay currently in force
//   dout_vld  out  1           delayed valid
//   dout      out  [DW]        delayed data, holds when dout_vld=0
//   dout_id   out  [IDW]       requester index of dout, holds with dout
//   gnt_cnt   out  [NREQ*16]   grant counters (GRANT_CNT_EN only)
// ----------------------------------------------------------------------------
module delay_line_arb #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int MAX_DLY = 8,
    localparam int IDW    = $clog2(NREQ),
    localparam int DLW    = $clog2(MAX_DLY + 1),
    localparam int SW     = $clog2(MAX_DLY)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    input  logic               cfg_wr,
    input  logic [DLW-1:0]     cfg_dly,
    output logic               cfg_busy,
    output logic [DLW-1:0]     cur_dly,
    output logic               dout_vld,
    output logic [DW-1:0]      dout,
    output logic [IDW-1:0]     dout_id
`ifdef GRANT_CNT_EN
   ,output logic [NREQ*16-1:0] gnt_cnt
`endif
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  ptr;
    logic [DLW-1:0]  pend_dly, pend_nx, cur_nx, cfg_clamped;

    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic [DW-1:0]   gnt_data;

    logic [MAX_DLY-1:0] stg_vld, act_mask;
    logic [DW-1:0]      stg_data [MAX_DLY];
    logic [IDW-1:0]     stg_id   [MAX_DLY];
    logic [SW-1:0]      sel;
    logic [DW-1:0]      hold_data;
    logic [IDW-1:0]     hold_id;
    logic               pipe_empty;

    // Clamp the requested delay into the legal range 1..MAX_DLY.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, otherwise an unassigned path infers a latch.
        cfg_clamped = cfg_dly;
        if (cfg_dly == '0)
            cfg_clamped = DLW'(1);
        else if (int'(cfg_dly) > MAX_DLY)
            cfg_clamped = DLW'(MAX_DLY);
    end

    // Round-robin search: first pass covers ptr..NREQ-1, second pass wraps
    // to 0..ptr-1 (indices already covered simply lose to gnt_any).
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        if (state == RUN && !rst) begin
            for (int j = 0; j < NREQ; j++) begin
                // NOTE: blocking assignments here, so gnt_any set in an
                // earlier iteration is seen by later ones in the same pass.
                if (!gnt_any && req[j] && j >= int'(ptr)) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = IDW'(j);
                    gnt_data = din[j*DW +: DW];
                end
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_any && req[j]) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = IDW'(j);
                    gnt_data = din[j*DW +: DW];
                end
            end
            if (gnt_any)
                gnt[gnt_idx] = 1'b1;
        end
    end

    // Stages at or beyond cur_dly never hold a valid bit: a word is dropped
    // from the valid chain once it has been presented, so a later increase
    // of cur_dly cannot resurrect stale words.
    always_comb begin
        act_mask = '0;
        for (int j = 0; j < MAX_DLY; j++)
            act_mask[j] = (j < int'(cur_dly));
    end

    assign pipe_empty = ~|stg_vld;
    assign sel        = SW'(cur_dly - DLW'(1));
    assign dout_vld   = stg_vld[sel];
    assign dout       = dout_vld ? stg_data[sel] : hold_data;
    assign dout_id    = dout_vld ? stg_id[sel]   : hold_id;
    assign cfg_busy   = (state == DRAIN);

    // Next-state logic: RUN accepts reconfiguration, DRAIN waits for empty.
    always_comb begin
        state_nx = state;
        pend_nx  = pend_dly;
        cur_nx   = cur_dly;
        case (state)
            RUN: begin
                if (cfg_wr && cfg_clamped != cur_dly) begin
                    pend_nx  = cfg_clamped;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (cfg_wr)
                    pend_nx = cfg_clamped;
                if (pipe_empty) begin
                    cur_nx   = pend_nx;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ptr       <= '0;
            pend_dly  <= DLW'(1);
            cur_dly   <= DLW'(1);
            stg_vld   <= '0;
            hold_data <= '0;
            hold_id   <= '0;
        end else begin
            state    <= state_nx;
            pend_dly <= pend_nx;
            cur_dly  <= cur_nx;
            if (gnt_any)
                ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            stg_vld <= {stg_vld[MAX_DLY-2:0], gnt_any} & act_mask;
            if (dout_vld) begin
                hold_data <= stg_data[sel];
                hold_id   <= stg_id[sel];
            end
        end
    end

    // NOTE: the data/id shift registers are not reset; the reset valid chain
    // already marks them as garbage, and leaving them out of reset keeps
    // them plain flops.
    always_ff @(posedge clk) begin
        stg_data[0] <= gnt_data;
        stg_id[0]   <= gnt_idx;
        for (int j = 1; j < MAX_DLY; j++) begin
            stg_data[j] <= stg_data[j-1];
            stg_id[j]   <= stg_id[j-1];
        end
    end

`ifdef GRANT_CNT_EN
    // Saturating per-requester grant counters; any cfg_wr clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt <= '0;
        end else if (cfg_wr) begin
            gnt_cnt <= '0;
        end else begin
            for (int j = 0; j < NREQ; j++) begin
                if (gnt[j] && gnt_cnt[j*16 +: 16] != 16'hFFFF)
                    gnt_cnt[j*16 +: 16] <= gnt_cnt[j*16 +: 16] + 16'd1;
            end
        end
    end
`else
    // No grant counters in this build.
`endif

endmodule

// File: tb/tb_delay_line_arb.sv
// ----------------------------------------------------------------------------
// tb_delay_line_arb
//   Directed, table-driven bench for delay_line_arb (NREQ=4, DW=8, MAX_DLY=8).
//   Each table row is one clock cycle: inputs driven after the falling edge,
//   outputs compared shortly after, before the next rising edge.
//   Hand-written sequences cover reset in the middle of a drain and, with
//   GRANT_CNT_EN, counter saturation and clearing.
// ----------------------------------------------------------------------------
module tb_delay_line_arb;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int MAX_DLY = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [31:0]      din;
    logic [3:0]       gnt;
    logic             cfg_wr;
    logic [3:0]       cfg_dly;
    logic             cfg_busy;
    logic [3:0]       cur_dly;
    logic             dout_vld;
    logic [7:0]       dout;
    logic [1:0]       dout_id;
`ifdef GRANT_CNT_EN
    logic [63:0]      gnt_cnt;
`endif

    delay_line_arb #(.NREQ(NREQ), .DW(DW), .MAX_DLY(MAX_DLY)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .cfg_wr   (cfg_wr),
        .cfg_dly  (cfg_dly),
        .cfg_busy (cfg_busy),
        .cur_dly  (cur_dly),
        .dout_vld (dout_vld),
        .dout     (dout),
        .dout_id  (dout_id)
`ifdef GRANT_CNT_EN
       ,.gnt_cnt  (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic        wr;
        logic [3:0]  dly;
        logic [3:0]  gnt;
        logic        vld;
        logic [7:0]  dout;
        logic [1:0]  id;
        logic        busy;
        logic [3:0]  cur;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] DA = 32'h1312_11A5;
    localparam logic [31:0] DB = 32'h1312_1110;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [31:0] d, input logic w,
                       input logic [3:0] dl, input logic [3:0] g, input logic v,
                       input logic [7:0] o, input logic [1:0] i, input logic b,
                       input logic [3:0] c);
        vec_t x;
        x.req = r; x.din = d; x.wr = w; x.dly = dl; x.gnt = g;
        x.vld = v; x.dout = o; x.id = i; x.busy = b; x.cur = c;
        vecs.push_back(x);
    endtask

    task automatic check_outs(input string tag, input vec_t x);
        check({tag, " gnt"},      32'(gnt),      32'(x.gnt));
        check({tag, " dout_vld"}, 32'(dout_vld), 32'(x.vld));
        check({tag, " dout"},     32'(dout),     32'(x.dout));
        check({tag, " dout_id"},  32'(dout_id),  32'(x.id));
        check({tag, " cfg_busy"}, 32'(cfg_busy), 32'(x.busy));
        check({tag, " cur_dly"},  32'(cur_dly),  32'(x.cur));
    endtask

    task automatic apply(input string tag, input vec_t x);
        @(negedge clk);
        req = x.req; din = x.din; cfg_wr = x.wr; cfg_dly = x.dly;
        #1;
        check_outs(tag, x);
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1; req = 4'b1111; din = DA; cfg_wr = 1'b0; cfg_dly = '0;
        #2;
        check("reset gnt",      32'(gnt),      0);
        check("reset dout_vld", 32'(dout_vld), 0);
        check("reset dout",     32'(dout),     0);
        check("reset dout_id",  32'(dout_id),  0);
        check("reset cfg_busy", 32'(cfg_busy), 0);
        check("reset cur_dly",  32'(cur_dly),  1);
        @(negedge clk);
        rst = 1'b0; req = 4'b0000;

        // ---------------- vector table ----------------
        //  req      din wr dly  gnt      vld dout   id busy cur
        // basic delay at cur_dly=1
        add(4'b0001, DA, 0, 0, 4'b0001, 0, 8'h00, 0, 0, 1);
        add(4'b0000, DA, 0, 0, 4'b0000, 1, 8'hA5, 0, 0, 1);
        add(4'b1000, DA, 0, 0, 4'b1000, 0, 8'hA5, 0, 0, 1);
        // reprogram to 3 with an empty pipe: one DRAIN cycle
        add(4'b0000, DA, 1, 3, 4'b0000, 1, 8'h13, 3, 0, 1);
        add(4'b0000, DA, 0, 0, 4'b0000, 0, 8'h13, 3, 1, 1);
        // round robin at cur_dly=3
        add(4'b1111, DB, 0, 0, 4'b0001, 0, 8'h13, 3, 0, 3);
        add(4'b1111, DB, 0, 0, 4'b0010, 0, 8'h13, 3, 0, 3);
        add(4'b1111, DB, 0, 0, 4'b0100, 0, 8'h13, 3, 0, 3);
        add(4'b1111, DB, 0, 0, 4'b1000, 1, 8'h10, 0, 0, 3);
        add(4'b1111, DB, 0, 0, 4'b0001, 1, 8'h11, 1, 0, 3);
        add(4'b1111, DB, 0, 0, 4'b0010, 1, 8'h12, 2, 0, 3);
        add(4'b1111, DB, 0, 0, 4'b0100, 1, 8'h13, 3, 0, 3);
        add(4'b1111, DB, 0, 0, 4'b1000, 1, 8'h10, 0, 0, 3);
        // reprogram to 2 with three words in flight
        add(4'b0000, DB, 1, 2, 4'b0000, 1, 8'h11, 1, 0, 3);
        add(4'b0000, DB, 0, 0, 4'b0000, 1, 8'h12, 2, 1, 3);
        add(4'b0000, DB, 0, 0, 4'b0000, 1, 8'h13, 3, 1, 3);
        add(4'b0000, DB, 0, 0, 4'b0000, 0, 8'h13, 3, 1, 3);
        // streaming at 2, cfg_wr 5 together with a grant
        add(4'b0001, DB, 0, 0, 4'b0001, 0, 8'h13, 3, 0, 2);
        add(4'b0011, DB, 0, 0, 4'b0010, 0, 8'h13, 3, 0, 2);
        add(4'b0011, DB, 1, 5, 4'b0001, 1, 8'h10, 0, 0, 2);
        add(4'b0011, DB, 0, 0, 4'b0000, 1, 8'h11, 1, 1, 2);
        add(4'b0011, DB, 0, 0, 4'b0000, 1, 8'h10, 0, 1, 2);
        add(4'b0011, DB, 0, 0, 4'b0000, 0, 8'h10, 0, 1, 2);
        add(4'b0011, DB, 0, 0, 4'b0010, 0, 8'h10, 0, 0, 5);
        for (int k = 0; k < 4; k++)
            add(4'b0000, DB, 0, 0, 4'b0000, 0, 8'h10, 0, 0, 5);
        add(4'b0000, DB, 0, 0, 4'b0000, 1, 8'h11, 1, 0, 5);
        add(4'b0000, DB, 0, 0, 4'b0000, 0, 8'h11, 1, 0, 5);
        // clamping: 0 -> 1, 12 -> 8
        add(4'b0000, DB, 1, 0,  4'b0000, 0, 8'h11, 1, 0, 5);
        add(4'b0000, DB, 0, 0,  4'b0000, 0, 8'h11, 1, 1, 5);
        add(4'b0000, DB, 1, 12, 4'b0000, 0, 8'h11, 1, 0, 1);
        add(4'b0000, DB, 0, 0,  4'b0000, 0, 8'h11, 1, 1, 1);
        // no-op write of the current delay while granting
        add(4'b0100, DB, 1, 8, 4'b0100, 0, 8'h11, 1, 0, 8);
        add(4'b0100, DB, 0, 0, 4'b0100, 0, 8'h11, 1, 0, 8);
        for (int k = 0; k < 6; k++)
            add(4'b0000, DB, 0, 0, 4'b0000, 0, 8'h11, 1, 0, 8);
        add(4'b0000, DB, 0, 0, 4'b0000, 1, 8'h12, 2, 0, 8);
        add(4'b0000, DB, 0, 0, 4'b0000, 1, 8'h12, 2, 0, 8);
        add(4'b0000, DB, 0, 0, 4'b0000, 0, 8'h12, 2, 0, 8);
        // three grants, the last with cfg_wr, then one DRAIN cycle
        add(4'b1111, DB, 0, 0, 4'b1000, 0, 8'h12, 2, 0, 8);
        add(4'b1111, DB, 0, 0, 4'b0001, 0, 8'h12, 2, 0, 8);
        add(4'b1111, DB, 1, 2, 4'b0010, 0, 8'h12, 2, 0, 8);
        add(4'b1111, DB, 0, 0, 4'b0000, 0, 8'h12, 2, 1, 8);

        foreach (vecs[n])
            apply($sformatf("v%0d", n), vecs[n]);

        // ---------------- reset mid-drain ----------------
        rst = 1'b1;
        #1;
        check("middrain gnt",      32'(gnt),      0);
        check("middrain dout_vld", 32'(dout_vld), 0);
        check("middrain dout",     32'(dout),     0);
        check("middrain cfg_busy", 32'(cfg_busy), 0);
        check("middrain cur_dly",  32'(cur_dly),  1);
        @(negedge clk);
        rst = 1'b0; req = 4'b0010; cfg_wr = 1'b0;
        #1;
        check("postrst gnt",      32'(gnt),      32'h2);
        check("postrst dout_vld", 32'(dout_vld), 0);
        @(negedge clk);
        req = 4'b0000;
        #1;
        check("postrst out vld",  32'(dout_vld), 1);
        check("postrst out data", 32'(dout),     32'h11);
        check("postrst out id",   32'(dout_id),  1);
        @(negedge clk);
        #1;
        check("postrst bubble",   32'(dout_vld), 0);
        check("postrst hold",     32'(dout),     32'h11);

`ifdef GRANT_CNT_EN
        // ---------------- grant counters ----------------
        check("cnt after reset", 32'(gnt_cnt[47:32]), 0);
        @(negedge clk);
        req = 4'b0100;
        repeat (70000) @(negedge clk);
        req = 4'b0000;
        #1;
        check("cnt sat req2", 32'(gnt_cnt[47:32]), 32'hFFFF);
        check("cnt req0",     32'(gnt_cnt[15:0]),  0);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_dly = 4'd1;
        @(negedge clk);
        cfg_wr = 1'b0;
        #1;
        check("cnt clr lo", gnt_cnt[31:0],  0);
        check("cnt clr hi", gnt_cnt[63:32], 0);
        check("cnt clr busy", 32'(cfg_busy), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_line_arb.md
Name: delay_line_arb

Overview:
Sequencer and arbiter for a shared programmable delay pipeline built from delay flip-flop stages. Up to NREQ requesters compete for the single pipeline input. A round-robin arbiter grants one requester per cycle. The granted data word, tagged with the requester ID, emerges exactly DLY cycles later. A config port reprograms DLY, and the controller drains the pipeline before applying the new value.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width per requester
MAX_DLY, 8, maximum programmable delay in cycles (pipeline depth)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  request per requester; level, held until granted
din  in  NREQ*DW  data; requester i occupies bits [i*DW +: DW]
gnt  out  NREQ  one-hot grant, combinational from req, state and pointer
cfg_wr  in  1  single-cycle strobe; load new delay
cfg_dly  in  $clog2(MAX_DLY+1)  requested delay
cfg_busy  out  1  high while a reconfiguration is pending or draining
cur_dly  out  $clog2(MAX_DLY+1)  delay currently in force
dout_vld  out  1  delayed valid
dout  out  DW  delayed data
dout_id  out  $clog2(NREQ)  requester index of dout

Behaviour:
- Reset (async, rst=1): FSM=RUN; rr pointer=0; all pipeline valid bits=0; dout=0; dout_id=0; dout_vld=0; cur_dly=1; cfg_busy=0; gnt=0 while rst is high.
- Arbitration (RUN only):
  - Search starts at index ptr and wraps modulo NREQ; the first asserted req wins.
  - gnt is one-hot or zero. It is never asserted in DRAIN.
  - On a posedge with a grant to requester k, the controller samples din[k] and k into stage 1 and sets ptr to (k+1) mod NREQ.
  - ptr is unchanged when there is no grant.
- Latency:
  - A word sampled at posedge T is presented with dout_vld=1 after posedge T+cur_dly-1.
  - cur_dly=1 behaves as a single flip-flop: the word is visible in the cycle after the grant edge.
  - Pipeline bubbles propagate as dout_vld=0. dout and dout_id hold their last value when dout_vld=0.
- Delay range:
  - cfg_dly=0 is clamped to 1.
  - cfg_dly>MAX_DLY is clamped to MAX_DLY.
  - Stages beyond cur_dly are bypassed through an output mux indexed by cur_dly.
- FSM states:
  - RUN: normal operation. cfg_wr with clamped value equal to cur_dly has no effect. cfg_wr with a different value latches pend_dly, sets cfg_busy=1, and moves to DRAIN on the next edge.
  - DRAIN: no grants. The pipeline keeps shifting with old cur_dly until all valid bits in stages 1..cur_dly are 0. At that point cur_dly<=pend_dly, cfg_busy<=0, and the FSM returns to RUN. The first grant is allowed in the cycle after the return. cfg_wr during DRAIN overwrites pend_dly; the last value wins.
  - Drain of an already-empty pipeline takes one cycle in DRAIN.
- Simultaneous events: a grant and a cfg_wr in the same RUN cycle are both honoured. The granted word enters the pipeline and is drained under the old delay.
- Reset mid-drain: everything returns to reset values. pend_dly is discarded.
- No word is ever dropped or duplicated. Each grant yields exactly one dout_vld pulse.

Optional Feature:
GRANT_CNT_EN
- Defined:
  - Adds output gnt_cnt [NREQ*16], one 16-bit counter per requester.
  - A counter increments on each grant and saturates at 16'hFFFF.
  - Counters clear on rst and on cfg_wr.
- Undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
1. Basic delay: reset, cur_dly=1; req=4'b0001, din[7:0]=8'hA5 for one grant at posedge T -> dout_vld=1, dout=8'hA5, dout_id=0 after posedge T; dout_vld=0 the next cycle.
2. Round-robin: req=4'b1111 held 8 cycles with din[i]=8'h10+i, cur_dly=3 -> gnt order 0,1,2,3,0,1,2,3; dout sequence 10,11,12,13,10,11,12,13 starting 3 cycles after the first grant; no bubbles.
3. Reconfigure: streaming at cur_dly=2, pulse cfg_wr with cfg_dly=5 -> cfg_busy=1 and gnt=0 until the two in-flight words exit. cur_dly becomes 5 and the next grant's data appears 5 cycles later.
4. Clamping and no-op: cfg_dly=0 -> cur_dly=1. cfg_dly=12 with MAX_DLY=8 -> cur_dly=8. cfg_wr with cfg_dly equal to cur_dly -> cfg_busy stays 0 and grants continue uninterrupted.
5. Reset mid-drain: assert rst during DRAIN with 3 words in flight -> dout_vld=0, cur_dly=1, cfg_busy=0 immediately. After release, a single request is granted and appears 1 cycle later.
6. (GRANT_CNT_EN) 70000 grants to requester 2 -> gnt_cnt[47:32]=16'hFFFF; a cfg_wr clears all counters to 0.
